trace_trigger_sequencer: RTL and testbench
==========================================

Name: trace_trigger_sequencer

Overview:
- Multi-stage trigger controller for the trace pattern matcher.
- Drives the matcher's per-rule pattern-enable vector one stage at a time and advances on qualified matches; a programmable inter-stage window aborts partial sequences.
- Emits a one-cycle final trigger with a saturating fire count, and supports auto re-arm after a holdoff.
- Sits in the TRACECLK domain, between the register block and the pattern matcher.

Parameters:
- pMATCH_RULES, 8, number of match rules / width of enable and match vectors
- pNUM_STAGES, 4, maximum sequence stages (power of two)
- pCOUNT_WIDTH, 16, width of window, holdoff and statistic counters

Ports:
- TRACECLK  input  1  trace clock; all logic on rising edge
- reset  input  1  active-low reset, synchronous to TRACECLK
- I_arm  input  1  pulse; start sequence from IDLE
- I_disarm  input  1  level or pulse; force IDLE
- I_stage_masks  input  pMATCH_RULES*pNUM_STAGES  rule mask per stage; stage k = bits [k*pMATCH_RULES +: pMATCH_RULES]
- I_last_stage  input  log2(pNUM_STAGES)  index of final stage (0 = single stage)
- I_window  input  pCOUNT_WIDTH  max cycles spent in stage>0 before abort; 0 = unlimited
- I_holdoff  input  pCOUNT_WIDTH  cycles in HOLDOFF before auto re-arm
- I_rearm_auto  input  1  1 = re-arm after fire; 0 = return to IDLE
- I_clear_counts  input  1  pulse; zero O_fire_count and O_timeout_count
- I_match_valid  input  1  one-cycle pulse from matcher: a match occurred
- I_match_bits  input  pMATCH_RULES  rules that matched, valid with I_match_valid
- O_pattern_enable  output  pMATCH_RULES  enable vector to matcher
- O_trig  output  1  one-cycle final trigger pulse
- O_state  output  2  0 IDLE, 1 ARMED, 2 FIRE, 3 HOLDOFF
- O_stage  output  log2(pNUM_STAGES)  current stage index
- O_fire_count  output  pCOUNT_WIDTH  saturating count of fires
- O_timeout_count  output  pCOUNT_WIDTH  saturating count of window aborts

Behaviour:
- Reset (reset low at clock edge): state IDLE, stage 0, all counters 0, O_trig 0, O_pattern_enable 0. A reset mid-sequence discards progress.
- O_pattern_enable: equals the stage mask of O_stage while ARMED; 0 in all other states. Registered, so it updates the cycle after a state or stage change.
- qualified_match = I_match_valid && |(I_match_bits & stage_mask[O_stage]). It is evaluated only in ARMED, so stale matches from a previous stage's enables are rejected by the mask.
- IDLE:
  - I_arm -> ARMED, stage 0, window counter 0.
  - I_arm outside IDLE is ignored.
- ARMED:
  - qualified_match with stage == I_last_stage -> FIRE.
  - qualified_match with stage < I_last_stage -> stage+1, window counter 0.
  - Otherwise, if stage>0 and I_window != 0, window counter increments. When counter+1 == I_window -> stage 0, counter 0, O_timeout_count+1.
  - Match and window expiry in the same cycle: match wins.
  - I_last_stage >= pNUM_STAGES is not possible by width; stages beyond I_last_stage are never entered.
- FIRE: exactly one cycle.
  - O_trig=1 in this cycle only, O_fire_count+1.
  - Next: HOLDOFF if I_rearm_auto, else IDLE.
- HOLDOFF:
  - Counter runs from 0. When counter == I_holdoff -> ARMED stage 0.
  - I_holdoff=0 gives exactly one HOLDOFF cycle.
  - Matches are ignored.
- I_disarm: highest priority in every state -> IDLE next cycle, stage 0. A FIRE already registered completes its pulse; no pulse is generated in the cycle disarm is sampled.
- Counters: saturate at all-ones, no wrap. I_clear_counts zeroes both counters. Clear and increment in the same cycle -> result 0.
- Latency: the qualified match on the final stage is sampled at edge N; O_trig is high during the cycle after edge N.

Optional Feature:
- Macro: TRACE_SEQ_TIMESTAMP_EN
- Defined:
  - Adds a free-running pCOUNT_WIDTH cycle counter, wrapping, zeroed by reset.
  - Adds output O_fire_timestamp [pCOUNT_WIDTH-1:0], which latches the counter value on entry to FIRE and holds until the next fire or reset (reset value 0).
  - Adds output O_stage_timestamp, which latches the counter on each stage advance.
- Not defined: these ports and the counter do not exist; all other behaviour is identical.

Test Plan:
- Single stage: I_last_stage=0, mask0=8'h01, arm, then match_bits=8'h01 pulse -> O_trig high exactly 1 cycle after the match edge; O_fire_count=1; state IDLE (rearm_auto=0).
- Three stages: masks 01/02/04, I_window=0, I_last_stage=2; match 8'h02 while in stage 0 -> ignored; then 01, 02, 04 -> stage 0,1,2 then O_trig; O_pattern_enable follows 01, 02, 04, 00.
- Window abort: I_window=5, advance to stage 1, no match for 5 cycles -> stage 0, O_timeout_count=1, O_pattern_enable back to mask0. Match on the 5th cycle -> advances instead, no timeout.
- Auto re-arm: I_rearm_auto=1, I_holdoff=3, fire -> state 3 for 4 cycles, then ARMED stage 0; match during holdoff -> no advance.
- Disarm and reset priority:
  - disarm asserted with a final-stage match in the same cycle -> no O_trig, IDLE.
  - reset low mid stage 2 -> all outputs at reset values next cycle.
- Saturation: preload via 2^16 fires (or a forced counter), one more fire -> O_fire_count stays 16'hFFFF; I_clear_counts coincident with a fire -> 0.

Source files
------------

// File: rtl/trace_trigger_sequencer.sv
// trace_trigger_sequencer: multi-stage trigger controller for the trace
// pattern matcher. Steps through per-stage rule masks on qualified matches,
// aborts partial sequences on an inter-stage window, fires a one-cycle
// trigger with saturating statistics and optional auto re-arm.
// Optional build macro TRACE_SEQ_TIMESTAMP_EN adds a free-running cycle
// counter with fire/stage-advance timestamp outputs.
module trace_trigger_sequencer #(
  parameter int unsigned pMATCH_RULES = 8,
  parameter int unsigned pNUM_STAGES  = 4,
  parameter int unsigned pCOUNT_WIDTH = 16
) (
  input  logic                                  TRACECLK,
  input  logic                                  reset,
  input  logic                                  I_arm,
  input  logic                                  I_disarm,
  input  logic [pMATCH_RULES*pNUM_STAGES-1:0]   I_stage_masks,
  input  logic [$clog2(pNUM_STAGES)-1:0]        I_last_stage,
  input  logic [pCOUNT_WIDTH-1:0]               I_window,
  input  logic [pCOUNT_WIDTH-1:0]               I_holdoff,
  input  logic                                  I_rearm_auto,
  input  logic                                  I_clear_counts,
  input  logic                                  I_match_valid,
  input  logic [pMATCH_RULES-1:0]               I_match_bits,
  output logic [pMATCH_RULES-1:0]               O_pattern_enable,
  output logic                                  O_trig,
  output logic [1:0]                            O_state,
  output logic [$clog2(pNUM_STAGES)-1:0]        O_stage,
  output logic [pCOUNT_WIDTH-1:0]               O_fire_count,
`ifdef TRACE_SEQ_TIMESTAMP_EN
  output logic [pCOUNT_WIDTH-1:0]               O_fire_timestamp,
  output logic [pCOUNT_WIDTH-1:0]               O_stage_timestamp,
`endif
  output logic [pCOUNT_WIDTH-1:0]               O_timeout_count
);

  localparam int unsigned pSTAGE_W = $clog2(pNUM_STAGES);
  localparam logic [pSTAGE_W-1:0]     STAGE_ONE = pSTAGE_W'(1);
  localparam logic [pCOUNT_WIDTH-1:0] CNT_ONE   = pCOUNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_FIRE    = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_t;

  state_t                    r_state;
  logic [pSTAGE_W-1:0]       r_stage;
  logic [pCOUNT_WIDTH-1:0]   r_cnt;
  logic                      r_trig;
  logic [pMATCH_RULES-1:0]   r_pattern_enable;
  logic [pCOUNT_WIDTH-1:0]   r_fire_count;
  logic [pCOUNT_WIDTH-1:0]   r_timeout_count;

  logic [pMATCH_RULES-1:0]   w_cur_mask;
  logic                      w_qual;
  logic                      w_armed_ok;
  logic                      w_win_active;
  logic                      w_win_expire;
  logic                      w_fire_inc;
  logic                      w_stage_adv;
  logic                      w_timeout_inc;

  assign w_cur_mask    = I_stage_masks[int'(r_stage)*pMATCH_RULES +: pMATCH_RULES];
  assign w_qual        = I_match_valid && (|(I_match_bits & w_cur_mask));
  assign w_armed_ok    = !I_disarm && (r_state == ST_ARMED);
  assign w_win_active  = (r_stage != '0) && (I_window != '0);
  assign w_win_expire  = ((r_cnt + CNT_ONE) == I_window);
  assign w_fire_inc    = w_armed_ok && w_qual && (r_stage == I_last_stage);
  assign w_stage_adv   = w_armed_ok && w_qual && (r_stage != I_last_stage);
  assign w_timeout_inc = w_armed_ok && !w_qual && w_win_active && w_win_expire;

  // Sequencer FSM: state, stage, shared window/holdoff counter, trigger and enables
  always_ff @(posedge TRACECLK) begin
    if (!reset) begin
      r_state          <= ST_IDLE;
      r_stage          <= '0;
      r_cnt            <= '0;
      r_trig           <= 1'b0;
      r_pattern_enable <= '0;
    end else begin
      r_trig           <= 1'b0;
      // Enable vector lags the state/stage registers by one cycle
      r_pattern_enable <= (r_state == ST_ARMED) ? w_cur_mask : '0;
      if (I_disarm) begin
        r_state <= ST_IDLE;
        r_stage <= '0;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (I_arm) begin
              r_state <= ST_ARMED;
              r_stage <= '0;
              r_cnt   <= '0;
            end
          end
          ST_ARMED: begin
            if (w_qual) begin
              if (r_stage == I_last_stage) begin
                r_state <= ST_FIRE;
                r_trig  <= 1'b1;
              end else begin
                r_stage <= r_stage + STAGE_ONE;
                r_cnt   <= '0;
              end
            end else if (w_win_active) begin
              if (w_win_expire) begin
                r_stage <= '0;
                r_cnt   <= '0;
              end else begin
                r_cnt <= r_cnt + CNT_ONE;
              end
            end
          end
          ST_FIRE: begin
            r_state <= I_rearm_auto ? ST_HOLDOFF : ST_IDLE;
            r_stage <= '0;
            r_cnt   <= '0;
          end
          default: begin
            if (r_cnt == I_holdoff) begin
              r_state <= ST_ARMED;
              r_stage <= '0;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
        endcase
      end
    end
  end

  // Saturating statistics; a clear wins over a coincident increment
  always_ff @(posedge TRACECLK) begin
    if (!reset) begin
      r_fire_count    <= '0;
      r_timeout_count <= '0;
    end else if (I_clear_counts) begin
      r_fire_count    <= '0;
      r_timeout_count <= '0;
    end else begin
      if (w_fire_inc && (r_fire_count != '1))
        r_fire_count <= r_fire_count + CNT_ONE;
      if (w_timeout_inc && (r_timeout_count != '1))
        r_timeout_count <= r_timeout_count + CNT_ONE;
    end
  end

`ifdef TRACE_SEQ_TIMESTAMP_EN
  logic [pCOUNT_WIDTH-1:0] r_ts;
  logic [pCOUNT_WIDTH-1:0] r_fire_ts;
  logic [pCOUNT_WIDTH-1:0] r_stage_ts;

  // Free-running wrapping cycle counter with fire/stage-advance capture
  always_ff @(posedge TRACECLK) begin
    if (!reset) begin
      r_ts       <= '0;
      r_fire_ts  <= '0;
      r_stage_ts <= '0;
    end else begin
      r_ts <= r_ts + CNT_ONE;
      if (w_fire_inc)
        r_fire_ts <= r_ts;
      if (w_stage_adv)
        r_stage_ts <= r_ts;
    end
  end

  assign O_fire_timestamp  = r_fire_ts;
  assign O_stage_timestamp = r_stage_ts;
`endif

  assign O_pattern_enable = r_pattern_enable;
  assign O_trig           = r_trig;
  assign O_state          = r_state;
  assign O_stage          = r_stage;
  assign O_fire_count     = r_fire_count;
  assign O_timeout_count  = r_timeout_count;

endmodule

// File: tb/tb_trace_trigger_sequencer.sv
// Testbench for trace_trigger_sequencer: directed vectors, with trigger
// events checked by a scoreboard monitor against expected fire counts.
module tb_trace_trigger_sequencer;

  logic        TRACECLK = 1'b0;
  logic        reset;
  logic        I_arm, I_disarm, I_rearm_auto, I_clear_counts, I_match_valid;
  logic [31:0] I_stage_masks;
  logic [1:0]  I_last_stage;
  logic [15:0] I_window, I_holdoff;
  logic [7:0]  I_match_bits;
  logic [7:0]  O_pattern_enable;
  logic        O_trig;
  logic [1:0]  O_state, O_stage;
  logic [15:0] O_fire_count, O_timeout_count;
`ifdef TRACE_SEQ_TIMESTAMP_EN
  logic [15:0] O_fire_timestamp, O_stage_timestamp;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [15:0] exp_q[$];

  trace_trigger_sequencer #(
    .pMATCH_RULES(8),
    .pNUM_STAGES(4),
    .pCOUNT_WIDTH(16)
  ) dut (
    .TRACECLK(TRACECLK),
    .reset(reset),
    .I_arm(I_arm),
    .I_disarm(I_disarm),
    .I_stage_masks(I_stage_masks),
    .I_last_stage(I_last_stage),
    .I_window(I_window),
    .I_holdoff(I_holdoff),
    .I_rearm_auto(I_rearm_auto),
    .I_clear_counts(I_clear_counts),
    .I_match_valid(I_match_valid),
    .I_match_bits(I_match_bits),
    .O_pattern_enable(O_pattern_enable),
    .O_trig(O_trig),
    .O_state(O_state),
    .O_stage(O_stage),
    .O_fire_count(O_fire_count),
`ifdef TRACE_SEQ_TIMESTAMP_EN
    .O_fire_timestamp(O_fire_timestamp),
    .O_stage_timestamp(O_stage_timestamp),
`endif
    .O_timeout_count(O_timeout_count)
  );

  always #5 TRACECLK = ~TRACECLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge TRACECLK);
  endtask

  task automatic pulse_match(input logic [7:0] bits);
    I_match_valid = 1'b1;
    I_match_bits  = bits;
    tick();
    I_match_valid = 1'b0;
    I_match_bits  = '0;
  endtask

  task automatic arm();
    I_arm = 1'b1;
    tick();
    I_arm = 1'b0;
  endtask

  task automatic disarm();
    I_disarm = 1'b1;
    tick();
    I_disarm = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] last, input logic [15:0] win,
                     input logic [15:0] hold, input logic rearm, input logic [31:0] masks);
    I_last_stage  = last;
    I_window      = win;
    I_holdoff     = hold;
    I_rearm_auto  = rearm;
    I_stage_masks = masks;
  endtask

  // Scoreboard monitor: every trigger pulse must match a queued expectation
  always @(negedge TRACECLK) begin
    if (reset && O_trig) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_trig: got trig with fire_count %0h expected no trig", O_fire_count);
      end else begin
        check("sb_fire_count", {16'h0, O_fire_count}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; I_arm = 0; I_disarm = 0; I_clear_counts = 0;
    I_match_valid = 0; I_match_bits = '0;
    cfg(2'd0, 16'd0, 16'd0, 1'b0, 32'h0000_0001);
    tick(); tick();
    check("rst_state", O_state, 0);
    check("rst_pe", O_pattern_enable, 0);
    check("rst_fire", O_fire_count, 0);
    reset = 1'b1;
    tick();

    // Single stage fire
    arm();
    check("s1_armed", O_state, 1);
    tick();
    check("s1_pe", O_pattern_enable, 8'h01);
    exp_q.push_back(16'd1);
    pulse_match(8'h01);
    check("s1_trig_hi", O_trig, 1);
    check("s1_state_fire", O_state, 2);
    tick();
    check("s1_trig_lo", O_trig, 0);
    check("s1_idle", O_state, 0);
    check("s1_count", O_fire_count, 1);

    // Three stages, wrong-stage match rejected
    cfg(2'd2, 16'd0, 16'd0, 1'b0, 32'h0004_0201);
    arm(); tick();
    pulse_match(8'h02);
    check("s3_reject_stage", O_stage, 0);
    check("s3_reject_state", O_state, 1);
    pulse_match(8'h01);
    check("s3_stage1", O_stage, 1);
    tick();
    check("s3_pe1", O_pattern_enable, 8'h02);
    pulse_match(8'h02);
    check("s3_stage2", O_stage, 2);
    tick();
    check("s3_pe2", O_pattern_enable, 8'h04);
    exp_q.push_back(16'd2);
    pulse_match(8'h04);
    check("s3_trig", O_trig, 1);
    tick();
    check("s3_pe_off", O_pattern_enable, 8'h00);
    check("s3_idle", O_state, 0);

    // Window abort after 5 idle cycles in stage 1
    cfg(2'd2, 16'd5, 16'd0, 1'b0, 32'h0004_0201);
    arm(); tick();
    pulse_match(8'h01);
    repeat (4) tick();
    check("win_still_s1", O_stage, 1);
    tick();
    check("win_abort_stage", O_stage, 0);
    check("win_timeouts", O_timeout_count, 1);
    tick();
    check("win_pe_back", O_pattern_enable, 8'h01);
    // Match on the 5th cycle advances instead
    pulse_match(8'h01);
    repeat (4) tick();
    pulse_match(8'h02);
    check("win_match_wins", O_stage, 2);
    check("win_no_timeout", O_timeout_count, 1);
    disarm();
    check("win_disarm", O_state, 0);

    // Auto re-arm with holdoff 3 and matches ignored in holdoff
    cfg(2'd0, 16'd0, 16'd3, 1'b1, 32'h0000_0001);
    arm(); tick();
    exp_q.push_back(16'd3);
    pulse_match(8'h01);
    check("ho_fire", O_state, 2);
    for (int i = 0; i < 4; i++) begin
      I_match_valid = 1'b1; I_match_bits = 8'h01;
      tick();
      check($sformatf("ho_state_%0d", i), O_state, 3);
    end
    I_match_valid = 1'b0; I_match_bits = '0;
    tick();
    check("ho_rearmed", O_state, 1);
    check("ho_stage0", O_stage, 0);
    check("ho_count", O_fire_count, 3);
    I_rearm_auto = 1'b0;
    disarm();

    // Disarm beats a final-stage match
    cfg(2'd0, 16'd0, 16'd0, 1'b0, 32'h0000_0001);
    arm(); tick();
    I_disarm = 1'b1; I_match_valid = 1'b1; I_match_bits = 8'h01;
    tick();
    I_disarm = 1'b0; I_match_valid = 1'b0; I_match_bits = '0;
    check("dis_no_trig", O_trig, 0);
    check("dis_idle", O_state, 0);
    check("dis_count", O_fire_count, 3);

    // Reset mid stage 2
    cfg(2'd2, 16'd0, 16'd0, 1'b0, 32'h0004_0201);
    arm(); tick();
    pulse_match(8'h01);
    pulse_match(8'h02);
    tick();
    check("mid_stage2", O_stage, 2);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mr_state", O_state, 0);
    check("mr_stage", O_stage, 0);
    check("mr_pe", O_pattern_enable, 0);
    check("mr_trig", O_trig, 0);
    check("mr_fire", O_fire_count, 0);
    check("mr_timeout", O_timeout_count, 0);

    // Saturation via a preloaded counter
    cfg(2'd0, 16'd0, 16'd0, 1'b0, 32'h0000_0001);
    force dut.r_fire_count = 16'hFFFE;
    tick();
    release dut.r_fire_count;
    arm(); tick();
    exp_q.push_back(16'hFFFF);
    pulse_match(8'h01);
    tick();
    arm(); tick();
    exp_q.push_back(16'hFFFF);
    pulse_match(8'h01);
    tick();
    check("sat_hold", O_fire_count, 16'hFFFF);
    // Clear coincident with a fire
    arm(); tick();
    exp_q.push_back(16'h0000);
    I_clear_counts = 1'b1; I_match_valid = 1'b1; I_match_bits = 8'h01;
    tick();
    I_clear_counts = 1'b0; I_match_valid = 1'b0; I_match_bits = '0;
    check("clr_trig", O_trig, 1);
    check("clr_count", O_fire_count, 0);
    tick(); tick();

    check("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
